// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern ROM sequencer: default geometry, FSM encodings
// and the window-address clamp.
package pattern_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned MOD_DEF    = 10;
  localparam int unsigned CAP_W_DEF  = 16;
  localparam int unsigned CNT_W      = 5;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSE  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Window bounds outside the address space are pulled down to the top address.
  function automatic int unsigned clamp_addr(input int unsigned a, input int unsigned m);
    return (a > m - 1) ? m - 1 : a;
  endfunction

endpackage

// File: rtl/mod_incr.sv
// Modulo-MOD address incrementer: MOD-1 wraps to 0.
module mod_incr #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned MOD    = 10
) (
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] a_next
);

  assign a_next = (a == ADDR_W'(MOD - 1)) ? '0 : a + ADDR_W'(1);

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Window sequencer for the pattern ROM + 16:1 bit-select path, with a START/BUSY/DONE
// handshake, HOLD/ABORT control and a shift register capturing the selected bit.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MOD    = MOD_DEF,
  parameter int unsigned CAP_W  = CAP_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] FIRST,
  input  logic [ADDR_W-1:0] LAST,
  input  logic              LOOP,
  input  logic              HOLD,
  input  logic              ABORT,
  input  logic              BIT_IN,
  output logic [ADDR_W-1:0] ADDR,
  output logic              VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic [CAP_W-1:0]  CAP,
  output logic [CNT_W-1:0]  CAP_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CAP_W);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CAP_W-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] first_clamped;
  logic [ADDR_W-1:0] last_clamped;

  assign first_clamped = ADDR_W'(clamp_addr(32'(FIRST), MOD));
  assign last_clamped  = ADDR_W'(clamp_addr(32'(LAST), MOD));

  mod_incr #(
    .ADDR_W(ADDR_W),
    .MOD   (MOD)
  ) u_incr (
    .a     (addr_q),
    .a_next(addr_inc)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a value unassigned (no latches).
    state_d   = state_q;
    first_d   = first_q;
    last_d    = last_q;
    addr_d    = addr_q;
    cap_d     = cap_q;
    cap_cnt_d = cap_cnt_q;

    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          first_d   = first_clamped;
          last_d    = last_clamped;
          addr_d    = first_clamped;
          cap_d     = '0;
          cap_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (HOLD) begin
          state_d = PAUSE;
        end else begin
          cap_d = {cap_q[CAP_W-2:0], BIT_IN};
          if (cap_cnt_q != CNT_MAX) cap_cnt_d = cap_cnt_q + CNT_W'(1);
          // A window with FIRST > LAST wraps through MOD-1 -> 0 before reaching LAST.
          if (addr_q != last_q)  addr_d  = addr_inc;
          else if (LOOP)         addr_d  = first_q;
          else                   state_d = FINISH;
        end
      end
      PAUSE: begin
        if (ABORT)      state_d = IDLE;
        else if (!HOLD) state_d = RUN;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == PAUSE);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      first_q   <= '0;
      last_q    <= '0;
      addr_q    <= '0;
      cap_q     <= '0;
      cap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      first_q   <= first_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      cap_q     <= cap_d;
      cap_cnt_q <= cap_cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ADDR    = addr_q;
  assign VALID   = valid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign CAP     = cap_q;
  assign CAP_CNT = cap_cnt_q;

endmodule
